// File: rtl/jtsdram_test_seq.sv
`default_nettype none
// ============================================================================
// jtsdram_test_seq : launches the JTSDRAM bank checkers one at a time or all
//                    together, repeats passes and collects sticky results.
// Revision: 1.0
// ============================================================================
module jtsdram_test_seq #(
    parameter int BANKS = 4,
    parameter int TOW   = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    input  logic [BANKS-1:0] mask,
    input  logic             concurrent,
    input  logic             slow_en,
    input  logic [7:0]       npass,
    input  logic [BANKS-1:0] bank_done,
    input  logic [BANKS-1:0] bank_bad,
    output logic [BANKS-1:0] start,
    output logic             slow,
    output logic             busy,
    output logic             finished,
    output logic [7:0]       pass_cnt,
    output logic [BANKS-1:0] bad_flags,
    output logic [BANKS-1:0] tout_flags,
    output logic [1:0]       cur_bank,
    output logic             ok
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_ARM    = 3'd2,
        S_WAIT   = 3'd3,
        S_NEXT   = 3'd4,
        S_FINISH = 3'd5
    } state_t;

    localparam logic [TOW-1:0] c_tout_max = '1;

    function automatic logic [1:0] lowest(input logic [BANKS-1:0] v);
        lowest = 2'd0;
        for (int i = BANKS - 1; i >= 0; i--)
            if (v[i]) lowest = 2'(i);
    endfunction

    function automatic logic [BANKS-1:0] onehot(input logic [1:0] b);
        onehot = '0;
        for (int i = 0; i < BANKS; i++)
            if (b == 2'(i)) onehot[i] = 1'b1;
    endfunction

    function automatic logic [BANKS-1:0] above(input logic [1:0] b);
        above = '0;
        for (int i = 0; i < BANKS; i++)
            if (2'(i) > b) above[i] = 1'b1;
    endfunction

    state_t           r_state, w_state_n;
    logic [BANKS-1:0] r_mask, w_mask_n;
    logic             r_conc, w_conc_n;
    logic             r_slow_en, w_slow_en_n;
    logic [7:0]       r_npass, w_npass_n;
    logic [TOW-1:0]   r_tcnt, w_tcnt_n, w_tcnt_inc;

    logic [BANKS-1:0] r_start, w_start_n;
    logic             r_slow, w_slow_n;
    logic             r_busy, w_busy_n;
    logic             r_fin, w_fin_n;
    logic [7:0]       r_pass, w_pass_n, w_pass_inc;
    logic [BANKS-1:0] r_bad, w_bad_n;
    logic [BANKS-1:0] r_tout, w_tout_n;
    logic [1:0]       r_cur, w_cur_n;
    logic             r_ok, w_ok_n;

    logic [BANKS-1:0] w_cur_oh, w_launch, w_pending, w_higher;

    always_comb begin
        w_state_n   = r_state;
        w_mask_n    = r_mask;
        w_conc_n    = r_conc;
        w_slow_en_n = r_slow_en;
        w_npass_n   = r_npass;
        w_tcnt_n    = r_tcnt;
        w_start_n   = '0;
        w_slow_n    = r_slow;
        w_pass_n    = r_pass;
        w_bad_n     = r_bad;
        w_tout_n    = r_tout;
        w_cur_n     = r_cur;

        w_cur_oh   = onehot(r_cur);
        // Timed-out banks are never relaunched; their slot simply completes.
        w_launch   = r_conc ? (r_mask & ~r_tout) : (w_cur_oh & ~r_tout);
        w_pending  = r_conc ? (r_mask & ~r_tout & ~bank_done) : (w_cur_oh & ~bank_done);
        w_higher   = r_mask & above(r_cur);
        w_tcnt_inc = (r_tcnt == c_tout_max) ? r_tcnt : r_tcnt + 1'b1;
        w_pass_inc = (r_pass == 8'hFF) ? r_pass : r_pass + 8'd1;

        case (r_state)
            S_IDLE, S_FINISH: begin
                if (go) begin
                    w_mask_n    = mask;
                    w_conc_n    = concurrent;
                    w_slow_en_n = slow_en;
                    w_npass_n   = npass;
                    w_pass_n    = 8'd0;
                    w_bad_n     = '0;
                    w_tout_n    = '0;
                    w_slow_n    = 1'b0;
                    w_cur_n     = concurrent ? 2'd0 : lowest(mask);
                    w_state_n   = (mask == '0) ? S_FINISH : S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_tcnt_n  = '0;
                w_start_n = w_launch;
                w_state_n = (w_launch == '0) ? S_NEXT : S_ARM;
            end
            // Checkers clear done on the edge that samples start, so done is
            // not trustworthy until the following cycle.
            S_ARM: w_state_n = S_WAIT;
            S_WAIT: begin
                w_bad_n  = r_bad | (bank_bad & r_mask);
                w_tcnt_n = w_tcnt_inc;
                if (w_pending == '0) begin
                    w_state_n = S_NEXT;
                end else if (w_tcnt_inc == c_tout_max) begin
                    w_tout_n  = r_tout | w_pending;
                    w_state_n = S_NEXT;
                end
            end
            S_NEXT: begin
                if (!r_conc && w_higher != '0) begin
                    w_cur_n   = lowest(w_higher);
                    w_state_n = S_LAUNCH;
                end else begin
                    w_pass_n = w_pass_inc;
                    if (r_npass != 8'd0 && w_pass_inc >= r_npass) begin
                        w_state_n = S_FINISH;
                    end else begin
                        w_cur_n   = r_conc ? 2'd0 : lowest(r_mask);
                        w_slow_n  = r_slow_en & w_pass_inc[0];
                        w_state_n = S_LAUNCH;
                    end
                end
            end
            default: w_state_n = S_IDLE;
        endcase

        if (abort) begin
            w_state_n = S_IDLE;
            w_start_n = '0;
            w_slow_n  = 1'b0;
        end

        w_busy_n = (w_state_n != S_IDLE) && (w_state_n != S_FINISH);
        w_fin_n  = (r_state == S_FINISH) && !go && !abort;
        w_ok_n   = w_fin_n && (w_bad_n == '0) && (w_tout_n == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mask    <= '0;
            r_conc    <= 1'b0;
            r_slow_en <= 1'b0;
            r_npass   <= 8'd0;
            r_tcnt    <= '0;
            r_start   <= '0;
            r_slow    <= 1'b0;
            r_busy    <= 1'b0;
            r_fin     <= 1'b0;
            r_pass    <= 8'd0;
            r_bad     <= '0;
            r_tout    <= '0;
            r_cur     <= 2'd0;
            r_ok      <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_mask    <= w_mask_n;
            r_conc    <= w_conc_n;
            r_slow_en <= w_slow_en_n;
            r_npass   <= w_npass_n;
            r_tcnt    <= w_tcnt_n;
            r_start   <= w_start_n;
            r_slow    <= w_slow_n;
            r_busy    <= w_busy_n;
            r_fin     <= w_fin_n;
            r_pass    <= w_pass_n;
            r_bad     <= w_bad_n;
            r_tout    <= w_tout_n;
            r_cur     <= w_cur_n;
            r_ok      <= w_ok_n;
        end
    end

    assign start      = r_start;
    assign slow       = r_slow;
    assign busy       = r_busy;
    assign finished   = r_fin;
    assign pass_cnt   = r_pass;
    assign bad_flags  = r_bad;
    assign tout_flags = r_tout;
    assign cur_bank   = r_cur;
    assign ok         = r_ok;

endmodule
`default_nettype wire
